multicycle_core: RTL

Parametrised multi-cycle processor core for the assignment datapath. It is the next generation of the fixed 8-bit fetch/decode/execute/writeback machine, generalised in data width, register count and memory depths. It adds a program-load port, a start/done handshake, branches, stores, an illegal-opcode trap and a retired-instruction counter. Instruction and data memories are internal; the result is presented on `out` at halt.

---
 rtl/multicycle_core.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: parametrised five-stage (IF/ID/EX/MEM/WB) multi-cycle core
// with internal instruction/data memories, a program-load port, a start/done
// handshake, branches, stores, an illegal-opcode trap and a retired counter.
//
// Handshake: load_en is a write strobe accepted on any rising edge while the
// core sits in IDLE (ignored otherwise). start is a one-cycle request accepted
// on any rising edge in IDLE or HALT; busy rises the next cycle and stays high
// until the program halts, at which point done is held high (with out/err
// valid) until the next accepted start or rst.
module multicycle_core #(
    parameter int DATA_W     = 8,
    parameter int NREG       = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 16,
    parameter int OUT_REG    = 1,
    localparam int PCW = $clog2(IMEM_DEPTH),
    localparam int DAW = $clog2(DMEM_DEPTH),
    localparam int RIW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [PCW-1:0]    load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] out,
    output logic [PCW-1:0]    pc,
    output logic [15:0]       retired,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [RIW-1:0] OUT_IDX = RIW'(OUT_REG);

    state_t            state_q, state_d;
    logic [PCW-1:0]    pc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q, out_q;
    logic              taken_q, err_q;
    logic [15:0]       retired_q;
    logic [DATA_W-1:0] regs_q [NREG];

    // Memories are not reset; contents survive rst and start.
    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    // Instruction field decode from the latched instruction word
    logic [5:0]        op, funct;
    logic [RIW-1:0]    rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] imm_w;
    logic [PCW-1:0]    imm_pc;
    logic              rtype_ok, is_halt, is_legal;

    assign op     = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: RIW];
    assign rt_idx = ir_q[16 +: RIW];
    assign rd_idx = ir_q[11 +: RIW];
    assign imm_w  = DATA_W'({{16{ir_q[15]}}, ir_q[15:0]});
    // Branch offsets and jump targets both use the low PCW bits of the word.
    assign imm_pc = ir_q[PCW-1:0];

    assign rtype_ok = (op == OP_RTYPE) &&
                      (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                       funct == FN_OR  || funct == FN_SLT);
    assign is_halt  = (op == OP_HALT);
    assign is_legal = rtype_ok || op == OP_ADDI || op == OP_LW || op == OP_SW ||
                      op == OP_BEQ || op == OP_BNE || op == OP_J;

    // Execute-stage ALU result and branch condition
    logic [DATA_W-1:0] alu_d;
    logic              taken_d;

    always_comb begin
        alu_d   = a_q + imm_w;
        taken_d = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_d = a_q + b_q;
                FN_SUB:  alu_d = a_q - b_q;
                FN_AND:  alu_d = a_q & b_q;
                FN_OR:   alu_d = a_q | b_q;
                FN_SLT:  alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                default: alu_d = '0;
            endcase
        end
    end

    // Next PC chosen in MEM: jump target, taken branch, or sequential
    logic [PCW-1:0] pc_seq, pc_d;

    always_comb begin
        pc_seq = pc_q + PCW'(1);
        pc_d   = pc_seq;
        if (op == OP_J)
            pc_d = imm_pc;
        else if ((op == OP_BEQ || op == OP_BNE) && taken_q)
            pc_d = pc_seq + imm_pc;
    end

    // Write-back destination and value
    logic              wr_en;
    logic [RIW-1:0]    wr_idx;
    logic [DATA_W-1:0] wr_val;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = rt_idx;
        wr_val = alu_q;
        if (op == OP_RTYPE) begin
            wr_en  = 1'b1;
            wr_idx = rd_idx;
        end else if (op == OP_ADDI) begin
            wr_en = 1'b1;
        end else if (op == OP_LW) begin
            wr_en  = 1'b1;
            wr_val = mdr_q;
        end
    end

    // Next-state logic; halt and illegal words leave ID straight for HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_IF;
            S_IF:    state_d = S_ID;
            S_ID:    state_d = (is_halt || !is_legal) ? S_HALT : S_EX;
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = S_IF;
            S_HALT:  if (start) state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers, register file, PC and retired counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            taken_q   <= 1'b0;
            retired_q <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q      <= '0;
                        retired_q <= '0;
                        out_q     <= '0;
                        err_q     <= 1'b0;
                        for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
                    end
                end
                S_IF: ir_q <= imem[pc_q];
                S_ID: begin
                    a_q <= regs_q[rs_idx];
                    b_q <= regs_q[rt_idx];
                    if (is_halt || !is_legal) begin
                        out_q <= regs_q[OUT_IDX];
                        err_q <= !is_halt;
                    end
                end
                S_EX: begin
                    alu_q   <= alu_d;
                    taken_q <= taken_d;
                end
                S_MEM: begin
                    if (op == OP_LW) mdr_q <= dmem[alu_q[DAW-1:0]];
                    pc_q <= pc_d;
                end
                S_WB: begin
                    if (wr_en && wr_idx != '0) regs_q[wr_idx] <= wr_val;
                    if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Program load into instruction memory, accepted only while idle
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && load_en) imem[load_addr] <= load_data;
    end

    // Store write on the MEM-exit edge; suppressed if reset is asserted
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_MEM && op == OP_SW) dmem[alu_q[DAW-1:0]] <= b_q;
    end

    assign busy        = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                         (state_q == S_MEM) || (state_q == S_WB);
    assign done        = (state_q == S_HALT);
    assign err         = err_q;
    assign out         = out_q;
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule
